// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the iterative MixColumns engine: input state channel, output state channel, status.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, inv, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, inv, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns, COLS_PER_CYCLE columns per clock; MIXCOL_INV_EN adds InvMixColumns via latched inv.
// Latency 4/COLS_PER_CYCLE cycles from accept to out_valid; one state in flight.
// Backpressure: result held in DONE until out_ready; a new state is taken in the same cycle it drains.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mix_columns_seq_if.slave  io
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Columns processed together share a group; col always sits on a group boundary.
    localparam logic [1:0] CMASK = 2'(4 - COLS_PER_CYCLE);

    state_t           state, state_nxt;
    logic [1:0]       col;
    logic [3:0][31:0] work, work_nxt;
    logic             mode;
    logic             in_rdy, out_vld, busy_q, accept, last_grp;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                xt(a1) ^ xt(a2) ^ a2 ^ a3 ^ a0,
                xt(a2) ^ xt(a3) ^ a3 ^ a0 ^ a1,
                xt(a3) ^ xt(a0) ^ a0 ^ a1 ^ a2};
    endfunction

`ifdef MIXCOL_INV_EN
    // Coefficients 0e/0b/0d/09 decomposed into x8, x4, x2 and x terms.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd) ^ gmul(a0, 4'h9),
                gmul(a2, 4'he) ^ gmul(a3, 4'hb) ^ gmul(a0, 4'hd) ^ gmul(a1, 4'h9),
                gmul(a3, 4'he) ^ gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9)};
    endfunction
`else
    logic unused_inv;
    assign unused_inv = io.inv;
`endif

    // Column c lives in the MSB-first slot 3-c of the packed working register.
    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam logic [1:0] GRP = 2'(c) & CMASK;
        logic [31:0] mixed;
`ifdef MIXCOL_INV_EN
        assign mixed = mode ? inv_mix(work[3-c]) : fwd_mix(work[3-c]);
`else
        assign mixed = fwd_mix(work[3-c]);
`endif
        assign work_nxt[3-c] = (col == GRP) ? mixed : work[3-c];
    end

    assign last_grp = (col == CMASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        busy_q    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = ~rst;
                accept = io.in_valid & in_rdy;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy_q = 1'b1;
                if (last_grp) state_nxt = DONE;
            end
            DONE: begin
                busy_q  = 1'b1;
                out_vld = 1'b1;
                in_rdy  = ~rst & io.out_ready;
                accept  = io.in_valid & in_rdy;
                if (io.out_ready) state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            col  <= '0;
            mode <= 1'b0;
        end else if (accept) begin
            work <= io.state_in;
            col  <= '0;
`ifdef MIXCOL_INV_EN
            mode <= io.inv;
`else
            mode <= 1'b0;
`endif
        end else if (state == RUN) begin
            work <= work_nxt;
            col  <= col + 2'(COLS_PER_CYCLE);
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.busy      = busy_q;
    assign io.state_out = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Drives three engines (1, 2 and 4 columns per cycle) from one directed sequence and checks each against hand-computed vectors.
module tb_mix_columns_seq;

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] state_in;
    logic         inv;
    logic         out_ready;

    logic         ov [3];
    logic         ir [3];
    logic         bz [3];
    logic [127:0] so [3];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq_if ifc ();
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk (clk),
            .rst (rst),
            .io  (ifc)
        );
        assign ifc.in_valid  = in_valid;
        assign ifc.state_in  = state_in;
        assign ifc.inv       = inv;
        assign ifc.out_ready = out_ready;
        assign ov[g] = ifc.out_valid;
        assign ir[g] = ifc.in_ready;
        assign bz[g] = ifc.busy;
        assign so[g] = ifc.state_out;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Accept one state, then follow every engine cycle by cycle until the slowest one has delivered.
    task automatic run(input string tag, input logic [127:0] vin, input logic vinv,
                       input logic [127:0] vexp);
        in_valid  = 1'b1;
        state_in  = vin;
        inv       = vinv;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("%s_in_ready_c%0d", tag, 1 << i), ir[i], 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = '0;
        inv      = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s_out_valid_c%0d_k%0d", tag, 1 << i, k), ov[i], (k == (4 >> i)));
                chk($sformatf("%s_busy_c%0d_k%0d", tag, 1 << i, k), bz[i], (k <= (4 >> i)));
                if (k == (4 >> i)) chk($sformatf("%s_state_out_c%0d", tag, 1 << i), so[i], vexp);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        state_in  = '0;
        inv       = 1'b0;
        out_ready = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid_c%0d", 1 << i), ov[i], 0);
            chk($sformatf("rst_state_out_c%0d", 1 << i), so[i], 0);
            chk($sformatf("rst_busy_c%0d", 1 << i), bz[i], 0);
            chk($sformatf("rst_in_ready_c%0d", 1 << i), ir[i], 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("post_rst_in_ready_c%0d", 1 << i), ir[i], 1);

        run("v1", V1, 1'b0, E1);
        run("v2", V2, 1'b0, E2);

        // Stall in DONE: result and flags must hold while out_ready is low.
        in_valid  = 1'b1;
        state_in  = V2;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = '0;
        for (int s = 1; s <= 8; s++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (s >= (4 >> i)) begin
                    chk($sformatf("stall_out_valid_c%0d_s%0d", 1 << i, s), ov[i], 1);
                    chk($sformatf("stall_state_out_c%0d_s%0d", 1 << i, s), so[i], E2);
                    chk($sformatf("stall_in_ready_c%0d_s%0d", 1 << i, s), ir[i], 0);
                end
            end
        end
        run("b2b", V1, 1'b0, E1);

        // Abort two cycles into RUN.
        in_valid = 1'b1;
        state_in = V1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_out_valid_c%0d", 1 << i), ov[i], 0);
            chk($sformatf("abort_state_out_c%0d", 1 << i), so[i], 0);
            chk($sformatf("abort_busy_c%0d", 1 << i), bz[i], 0);
            chk($sformatf("abort_in_ready_c%0d", 1 << i), ir[i], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("abort_release_in_ready_c%0d", 1 << i), ir[i], 1);
        run("fresh", V2, 1'b0, E2);

`ifdef MIXCOL_INV_EN
        run("inv", E1, 1'b1, V1);
`else
        run("inv_ignored", V1, 1'b1, E1);
`endif
        run("fwd_after_inv", V2, 1'b0, E2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
